// File: rtl/framer_o.sv
// framer_o -- serial optical-link framer.
//
// Builds a fixed 256-bit frame from eight 24-bit channel words and four user
// bits, then sends it out NRZI-encoded, one frame bit per mclk.
// A rising edge of wordclock latches fresh data and starts a new frame at bit 0.
// If no new edge arrives by the end of the frame, the same frame is sent again.
//
// Frame layout (bit index within the frame):
//   0..9    : 0        sync gap, so the line stays constant for 10 cycles
//   10      : 1
//   11..14  : user[3] .. user[0]
//   15      : 1
//   16..255 : ch1..ch8, 30 bits each. Each channel is sent as six nibbles,
//             MSB first, and every nibble is followed by a separator 1.
//
// Ports:
//   mclk        in   bit clock (256 x word rate). All logic uses its rising edge.
//   rst         in   synchronous, active-high reset
//   wordclock   in   frame strobe, mclk/256, synchronous to mclk
//   ch1..ch8    in   24-bit two's-complement sample words
//   user        in   4 user bits, sent once per frame
//   lightpipe   out  registered NRZI serial stream

module framer_o (
    input  logic        mclk,
    input  logic        rst,
    input  logic        wordclock,
    input  logic [23:0] ch1,
    input  logic [23:0] ch2,
    input  logic [23:0] ch3,
    input  logic [23:0] ch4,
    input  logic [23:0] ch5,
    input  logic [23:0] ch6,
    input  logic [23:0] ch7,
    input  logic [23:0] ch8,
    input  logic [3:0]  user,
    output logic        lightpipe
);

    logic              wc_q;
    logic              wc_rise;
    logic [7:0]        bit_cnt;
    logic [7:0]        next_cnt;
    logic [7:0][23:0]  shadow_ch;
    logic [3:0]        shadow_user;
    logic [255:0]      frame;
    logic              frame_bit;

    assign wc_rise  = wordclock & ~wc_q;

    // A wordclock edge forces bit 0, even in the middle of a frame.
    // Otherwise the counter steps by one and wraps naturally from 255 to 0,
    // which resends the stored frame.
    assign next_cnt = wc_rise ? 8'd0 : bit_cnt + 8'd1;

    // Build the full frame from the shadow copy of the inputs.
    // This is pure wiring: fixed 1s, the user field, and the channel
    // nibbles with their separator 1s. The bit counter then selects one bit.
    always_comb begin
        frame      = '0;
        frame[10]  = 1'b1;
        frame[15]  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame[11 + i] = shadow_user[3 - i];
        end
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 6; n++) begin
                for (int p = 0; p < 4; p++) begin
                    frame[16 + 30*k + 5*n + p] = shadow_ch[k][23 - 4*n - p];
                end
                frame[16 + 30*k + 5*n + 4] = 1'b1;
            end
        end
    end

    // Bit 0 is always 0, so the edge cycle never toggles the line.
    // That means the shadow register does not need to be bypassed for the
    // bit that is encoded on the same edge as the load.
    assign frame_bit = wc_rise ? 1'b0 : frame[next_cnt];

    // Register the strobe, step the bit counter, load the shadow register on
    // a wordclock edge, and NRZI-encode: a frame bit of 1 toggles the line.
    always_ff @(posedge mclk) begin
        if (rst) begin
            wc_q        <= 1'b0;
            bit_cnt     <= 8'd0;
            shadow_ch   <= '0;
            shadow_user <= 4'd0;
            lightpipe   <= 1'b0;
        end else begin
            wc_q      <= wordclock;
            bit_cnt   <= next_cnt;
            lightpipe <= lightpipe ^ frame_bit;
            if (wc_rise) begin
                shadow_ch   <= {ch8, ch7, ch6, ch5, ch4, ch3, ch2, ch1};
                shadow_user <= user;
            end
        end
    end

endmodule

// File: tb/tb_framer_o.sv
// tb_framer_o -- self-checking bench for framer_o.
// A frame-level reference model, built from the layout arithmetic, tracks the
// expected lightpipe level on every cycle. Decoded frames are also checked
// against hand-computed literal values.

module tb_framer_o;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        wordclock = 1'b0;
    logic [23:0] ch1, ch2, ch3, ch4, ch5, ch6, ch7, ch8;
    logic [3:0]  user;
    logic        lightpipe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 mclk = ~mclk;

    framer_o dut (
        .mclk      (mclk),
        .rst       (rst),
        .wordclock (wordclock),
        .ch1       (ch1),
        .ch2       (ch2),
        .ch3       (ch3),
        .ch4       (ch4),
        .ch5       (ch5),
        .ch6       (ch6),
        .ch7       (ch7),
        .ch8       (ch8),
        .user      (user),
        .lightpipe (lightpipe)
    );

    // Frame contents from the layout rules. chs packs ch1 in bits [23:0].
    function automatic logic [255:0] build_frame(input logic [191:0] chs, input logic [3:0] u);
        logic [255:0] f;
        int off, k, r, n, p;
        f = '0;
        for (int idx = 0; idx < 256; idx++) begin
            if (idx < 10)       f[idx] = 1'b0;
            else if (idx == 10) f[idx] = 1'b1;
            else if (idx < 15)  f[idx] = u[14 - idx];
            else if (idx == 15) f[idx] = 1'b1;
            else begin
                off = idx - 16;
                k = off / 30;
                r = off % 30;
                n = r / 5;
                p = r % 5;
                f[idx] = (p == 4) ? 1'b1 : chs[24*k + 23 - 4*n - p];
            end
        end
        return f;
    endfunction

    function automatic logic [23:0] decode_ch(input logic [255:0] f, input int k);
        logic [23:0] v;
        v = '0;
        for (int n = 0; n < 6; n++)
            for (int p = 0; p < 4; p++)
                v[23 - 4*n - p] = f[16 + 30*k + 5*n + p];
        return v;
    endfunction

    // Reference model: frame index, registered strobe and line level.
    logic         m_lp = 1'b0;
    logic         m_wcq = 1'b0;
    int           m_idx = 0;
    logic [255:0] m_frame = '0;
    bit           cmp_en = 1'b0;

    always @(posedge mclk) begin
        if (rst) begin
            m_lp    = 1'b0;
            m_wcq   = 1'b0;
            m_idx   = 0;
            m_frame = build_frame('0, 4'd0);
        end else begin
            if (wordclock && !m_wcq) begin
                m_frame = build_frame({ch8, ch7, ch6, ch5, ch4, ch3, ch2, ch1}, user);
                m_idx   = 0;
            end else begin
                m_idx = (m_idx + 1) % 256;
            end
            if (m_frame[m_idx]) m_lp = ~m_lp;
            m_wcq = wordclock;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge mclk) begin
        if (cmp_en) begin
            n_checks++;
            if (lightpipe !== m_lp) begin
                n_fail++;
                $display("[TB] FAIL lightpipe_model t=%0t idx=%0d actual=%b expected=%b",
                         $time, m_idx, lightpipe, m_lp);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [191:0] chs, input logic [3:0] u);
        {ch8, ch7, ch6, ch5, ch4, ch3, ch2, ch1} = chs;
        user = u;
    endtask

    // Stimulus state. Modes: 0 = static, 1 = inc/dec at each edge,
    // 2 = random every cycle, 3 = random at each edge.
    int           wc_phase = 0;
    bit           wc_hold  = 1'b0;
    int           stim_mode = 0;
    bit           last_rise = 1'b0;
    logic [191:0] cap_ch = '0;
    logic [3:0]   cap_user = '0;

    task automatic stepCycle();
        logic wc_new;
        @(negedge mclk);
        wc_new = wc_hold ? 1'b0 : (wc_phase < 128);
        last_rise = wc_new && !wordclock;
        if (stim_mode == 2 || (stim_mode == 3 && last_rise))
            applyStimulus({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 4'($urandom));
        if (stim_mode == 1 && last_rise) begin
            ch1 = ch1 - 1; ch3 = ch3 - 1; ch5 = ch5 - 1; ch7 = ch7 - 1;
            ch2 = ch2 + 1; ch4 = ch4 + 1; ch6 = ch6 + 1; ch8 = ch8 + 1;
            user = user + 1;
        end
        wordclock = wc_new;
        if (last_rise) begin
            cap_ch   = {ch8, ch7, ch6, ch5, ch4, ch3, ch2, ch1};
            cap_user = user;
        end
        wc_phase = (wc_phase + 1) % 256;
    endtask

    task automatic waitEdge();
        int guard = 0;
        do begin
            stepCycle();
            guard++;
        end while (!last_rise && guard < 600);
        if (!last_rise) checkOutput("edge_timeout", 32'd0, 32'd1);
    endtask

    // NRZI-decode the next 256 cycles starting from the current line level.
    task automatic recordFrame(output logic [255:0] f);
        logic prev;
        prev = lightpipe;
        for (int i = 0; i < 256; i++) begin
            stepCycle();
            f[i] = lightpipe ^ prev;
            prev = lightpipe;
        end
    endtask

    logic [255:0] f1, f2, f3;
    logic [191:0] snap_ch;
    logic [3:0]   snap_user;
    logic         lvl0;

    initial begin
        applyStimulus({6{32'h1234_5678}}, 4'hA);
        @(posedge mclk);
        cmp_en = 1'b1;

        // Reset held 4 cycles while wordclock toggles.
        wc_phase = 126;
        stim_mode = 2;
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("reset_lp", 32'(lightpipe), 32'd0);
        end

        // After release and with no edge yet, the empty frame still carries its 50 fixed 1s.
        rst = 1'b0;
        wc_hold = 1'b1;
        recordFrame(f1);
        checkOutput("empty_frame_ones", $countones(f1), 32'd50);

        // All-zero data.
        stim_mode = 0;
        applyStimulus('0, 4'd0);
        wc_hold = 1'b0;
        wc_phase = 0;
        waitEdge();
        lvl0 = lightpipe;
        recordFrame(f1);
        checkOutput("zero_ones", $countones(f1), 32'd50);
        checkOutput("zero_gap", 32'(f1[9:0]), 32'd0);
        checkOutput("zero_b10_b15_b20", {29'd0, f1[10], f1[15], f1[20]}, 32'd7);
        checkOutput("zero_b255", 32'(f1[255]), 32'd1);
        checkOutput("zero_level_repeat", 32'(lightpipe), 32'(lvl0));

        // Alternating full and empty channels, user = 3.
        applyStimulus({24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF,
                       24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF}, 4'd3);
        waitEdge();
        recordFrame(f1);
        checkOutput("alt_user_bits", {28'd0, f1[11], f1[12], f1[13], f1[14]}, 32'h3);
        checkOutput("alt_ch1_nib0", {27'd0, f1[16], f1[17], f1[18], f1[19], f1[20]}, 32'h1F);
        checkOutput("alt_ch2_nib0", {27'd0, f1[46], f1[47], f1[48], f1[49], f1[50]}, 32'h01);
        for (int k = 0; k < 8; k++)
            checkOutput($sformatf("alt_ch%0d", k + 1), 32'(decode_ch(f1, k)),
                        (k % 2 == 0) ? 32'hFFFFFF : 32'h0);

        // Counting data; ch1 passes 000000 -> FFFFFF -> FFFFFE.
        stim_mode = 1;
        applyStimulus({24'h0, 24'h1, 24'h0, 24'h1, 24'h0, 24'h1, 24'h0, 24'h1}, 4'd0);
        waitEdge();
        for (int j = 0; j < 4; j++) begin
            snap_ch = cap_ch;
            snap_user = cap_user;
            recordFrame(f1);
            for (int k = 0; k < 8; k++)
                checkOutput($sformatf("count_f%0d_ch%0d", j, k + 1), 32'(decode_ch(f1, k)),
                            32'(snap_ch[24*k +: 24]));
            checkOutput($sformatf("count_f%0d_user", j), {28'd0, f1[11], f1[12], f1[13], f1[14]},
                        32'(snap_user));
            if (j == 2) checkOutput("ch1_wrap", 32'(decode_ch(f1, 0)), 32'hFFFFFE);
        end

        // One edge, then wordclock held low for 3 frames while inputs churn.
        stim_mode = 2;
        waitEdge();
        wc_hold = 1'b1;
        snap_ch = cap_ch;
        snap_user = cap_user;
        recordFrame(f1);
        recordFrame(f2);
        recordFrame(f3);
        checkOutput("hold_frame1", 32'(f1 == build_frame(snap_ch, snap_user)), 32'd1);
        checkOutput("hold_repeat2", 32'(f2 == f1), 32'd1);
        checkOutput("hold_repeat3", 32'(f3 == f1), 32'd1);

        // Extra wordclock edge around bit 100 restarts the frame.
        stim_mode = 3;
        wc_hold = 1'b0;
        wc_phase = 0;
        waitEdge();
        repeat (100) stepCycle();
        wc_phase = 128;
        stepCycle();
        wc_phase = 0;
        stepCycle();
        checkOutput("extra_edge_seen", 32'(last_rise), 32'd1);
        snap_ch = cap_ch;
        snap_user = cap_user;
        recordFrame(f1);
        checkOutput("extra_gap", 32'(f1[9:0]), 32'd0);
        checkOutput("extra_b10", 32'(f1[10]), 32'd1);
        checkOutput("extra_frame", 32'(f1 == build_frame(snap_ch, snap_user)), 32'd1);

        // Reset in the middle of a frame.
        stim_mode = 2;
        repeat (50) stepCycle();
        rst = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("mid_reset_lp", 32'(lightpipe), 32'd0);
        rst = 1'b0;
        repeat (600) stepCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
